pwm_capture: RTL and testbench

Receive-side counterpart of the team's PWM generator: samples an asynchronous PWM line, measures high time and period in `clk` cycles, and reports a `WIDTH`-bit duty word directly comparable to the `duty` value that drove the generator. It sits on board inputs such as fan tachometers, servo feedback, or loop-back of our own PWM outputs. It also detects a stuck line, covering 0 % duty and a disabled generator.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/dffr.sv | 20 ++
 rtl/dffre.sv | 24 ++
 rtl/pwm_edge_sync.sv | 24 ++
 rtl/pwm_capture.sv | 156 +++++++++++++++
 tb/tb_pwm_capture.sv | 219 +++++++++++++++++++++
 6 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: default duty width
// and the capture FSM state encoding.
package pwm_pkg;

   localparam int PWM_WIDTH = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_ARM   = 2'd0;
   localparam state_t ST_HIGH  = 2'd1;
   localparam state_t ST_LOW   = 2'd2;
   localparam state_t ST_STUCK = 2'd3;

endpackage

// File: rtl/dffr.sv
// Library flop cell: W-bit register with synchronous active-high reset.
module dffr #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         r,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Register with reset-to-zero
   always_ff @(posedge clk) begin
      if (r) begin
         q <= {W{1'b0}};
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/dffre.sv
// Library flop cell: W-bit register with synchronous active-high reset and
// load enable.
module dffre #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         r,
   input  logic         e,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Register with reset-to-zero and hold when not enabled
   always_ff @(posedge clk) begin
      if (r) begin
         q <= {W{1'b0}};
      end else if (e) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for an asynchronous line, followed by a delay flop
// so that single-cycle rise/fall strobes can be derived.
module pwm_edge_sync (
   input  logic clk,
   input  logic r,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic r_s1;
   logic r_s2;
   logic r_prev;

   dffr #(.W(1)) u_s1   (.clk(clk), .r(r), .d(d),    .q(r_s1));
   dffr #(.W(1)) u_s2   (.clk(clk), .r(r), .d(r_s1), .q(r_s2));
   dffr #(.W(1)) u_prev (.clk(clk), .r(r), .d(r_s2), .q(r_prev));

   assign level = r_s2;
   assign rise  = r_s2 & ~r_prev;
   assign fall  = ~r_s2 & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM line in
// clk cycles, reports a saturated duty word and flags a line with no rises.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int WIDTH   = PWM_WIDTH,
   parameter int CNT_W   = WIDTH + 2,
   parameter int TIMEOUT = 2 ** (WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cycles,
   output logic [CNT_W-1:0] period_cycles,
   output logic [WIDTH-1:0] duty,
   output logic             period_match,
   output logic             stuck,
   output logic             stuck_level,
   output logic             meas_valid
);

   localparam logic [CNT_W-1:0] C_ZERO     = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] C_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] C_TIMEOUT  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] C_NOMINAL  = CNT_W'(2 ** WIDTH);
   localparam logic [WIDTH-1:0] C_DUTY_MAX = {WIDTH{1'b1}};

   function automatic logic [WIDTH-1:0] sat_duty(input logic [CNT_W-1:0] v);
      logic [WIDTH-1:0] res;
      if (v > CNT_W'(C_DUTY_MAX)) begin
         res = C_DUTY_MAX;
      end else begin
         res = v[WIDTH-1:0];
      end
      return res;
   endfunction

   logic             w_level;
   logic             w_rise;
   logic             w_fall;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_hi_tmp;
   logic             w_hi_load;
   logic             w_timeout;
   logic             w_meas;
   logic             w_upd;
   logic [CNT_W-1:0] w_high_nxt;
   logic [CNT_W-1:0] w_period_nxt;
   logic [WIDTH-1:0] w_duty_nxt;
   logic             w_match_nxt;
   logic             w_stuck_nxt;

   pwm_edge_sync u_sync (
      .clk   (clk),
      .r     (reset),
      .d     (pwm_in),
      .level (w_level),
      .rise  (w_rise),
      .fall  (w_fall)
   );

   // Cycles since last rise; saturation keeps it from wrapping on a dead line
   assign w_cnt_nxt = w_rise ? C_ONE :
                      (r_cnt == C_TIMEOUT) ? r_cnt : (r_cnt + C_ONE);

   assign w_timeout = (r_state != ST_STUCK) & ~w_rise & (r_cnt == C_TIMEOUT);
   assign w_meas    = (r_state == ST_LOW) & w_rise;
   assign w_upd     = w_meas | w_timeout;
   assign w_hi_load = (r_state == ST_HIGH) & w_fall & ~w_timeout;

   dffr  #(.W(CNT_W)) u_cnt    (.clk(clk), .r(reset), .d(w_cnt_nxt), .q(r_cnt));
   dffre #(.W(CNT_W)) u_hi_tmp (.clk(clk), .r(reset), .e(w_hi_load),
                                .d(r_cnt), .q(r_hi_tmp));

   // FSM state register
   dffr #(.W(2)) u_state (.clk(clk), .r(reset), .d(w_state_nxt), .q(r_state));

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ARM: begin
            if (w_rise) begin
               w_state_nxt = ST_HIGH;
            end else if (w_timeout) begin
               w_state_nxt = ST_STUCK;
            end else begin
               w_state_nxt = ST_ARM;
            end
         end
         ST_HIGH: begin
            if (w_timeout) begin
               w_state_nxt = ST_STUCK;
            end else if (w_fall) begin
               w_state_nxt = ST_LOW;
            end else begin
               w_state_nxt = ST_HIGH;
            end
         end
         ST_LOW: begin
            if (w_rise) begin
               w_state_nxt = ST_HIGH;
            end else if (w_timeout) begin
               w_state_nxt = ST_STUCK;
            end else begin
               w_state_nxt = ST_LOW;
            end
         end
         ST_STUCK: begin
            if (w_rise) begin
               w_state_nxt = ST_HIGH;
            end else begin
               w_state_nxt = ST_STUCK;
            end
         end
         default: begin
            w_state_nxt = ST_ARM;
         end
      endcase
   end

   // FSM output logic: values loaded into the result registers on update
   always_comb begin
      w_high_nxt   = r_hi_tmp;
      w_period_nxt = r_cnt;
      w_duty_nxt   = sat_duty(r_hi_tmp);
      w_stuck_nxt  = 1'b0;
      if (w_timeout) begin
         w_high_nxt   = w_level ? C_TIMEOUT : C_ZERO;
         w_period_nxt = C_TIMEOUT;
         w_duty_nxt   = w_level ? C_DUTY_MAX : {WIDTH{1'b0}};
         w_stuck_nxt  = 1'b1;
      end else begin
         w_stuck_nxt  = 1'b0;
      end
      w_match_nxt = (w_period_nxt == C_NOMINAL);
   end

   dffre #(.W(CNT_W)) u_high   (.clk(clk), .r(reset), .e(w_upd),
                                .d(w_high_nxt), .q(high_cycles));
   dffre #(.W(CNT_W)) u_period (.clk(clk), .r(reset), .e(w_upd),
                                .d(w_period_nxt), .q(period_cycles));
   dffre #(.W(WIDTH)) u_duty   (.clk(clk), .r(reset), .e(w_upd),
                                .d(w_duty_nxt), .q(duty));
   dffre #(.W(1))     u_match  (.clk(clk), .r(reset), .e(w_upd),
                                .d(w_match_nxt), .q(period_match));
   dffre #(.W(1))     u_stuck  (.clk(clk), .r(reset), .e(w_upd),
                                .d(w_stuck_nxt), .q(stuck));
   dffre #(.W(1))     u_slevel (.clk(clk), .r(reset), .e(w_timeout),
                                .d(w_level), .q(stuck_level));
   dffr  #(.W(1))     u_valid  (.clk(clk), .r(reset), .d(w_upd), .q(meas_valid));

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a time-stamp based reference model
// predicts every measurement, a monitor compares on each meas_valid.
module tb_pwm_capture;

   localparam int W     = 4;
   localparam int CW    = W + 2;
   localparam int TOUT  = 32;
   localparam int NOM   = 16;

   typedef struct packed {
      logic [CW-1:0] hi;
      logic [CW-1:0] per;
      logic [W-1:0]  dty;
      logic          match;
      logic          stk;
      logic          lvl;
   } rec_t;

   typedef enum int {M_ARM, M_HIGH, M_LOW, M_STUCK} mstate_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          pwm_in;
   logic [CW-1:0] high_cycles;
   logic [CW-1:0] period_cycles;
   logic [W-1:0]  duty;
   logic          period_match;
   logic          stuck;
   logic          stuck_level;
   logic          meas_valid;

   int   n_tests = 0;
   int   n_fail  = 0;
   rec_t exp_q[$];

   pwm_capture dut (
      .clk           (clk),
      .reset         (reset),
      .pwm_in        (pwm_in),
      .high_cycles   (high_cycles),
      .period_cycles (period_cycles),
      .duty          (duty),
      .period_match  (period_match),
      .stuck         (stuck),
      .stuck_level   (stuck_level),
      .meas_valid    (meas_valid)
   );

   always #5 clk = ~clk;

   function automatic rec_t mk(int hi, int per, int dty, bit m, bit s, bit l);
      rec_t r;
      r.hi    = hi[CW-1:0];
      r.per   = per[CW-1:0];
      r.dty   = dty[W-1:0];
      r.match = m;
      r.stk   = s;
      r.lvl   = l;
      return r;
   endfunction

   // Reference model. Works in "sample index" time: the line value sampled at
   // posedge k is judged as one event at k, and every event reaches the outputs
   // with the same fixed delay, so only the order of results matters.
   mstate_t ms        = M_ARM;
   int      cyc       = 0;
   int      last_rise = 0;
   int      hi_len    = 0;
   bit      prev_l    = 1'b0;
   bit      last_lvl  = 1'b0;
   bit      d1        = 1'b0;
   bit      d2        = 1'b0;

   task automatic model_step(input int k, input bit l);
      bit rise;
      bit fall;
      int el;
      rise   = l & ~prev_l;
      fall   = ~l & prev_l;
      prev_l = l;
      el     = k - last_rise;
      if (rise) begin
         if (ms == M_LOW) begin
            exp_q.push_back(mk(hi_len, el, (hi_len > 15) ? 15 : hi_len,
                               el == NOM, 1'b0, last_lvl));
         end
         ms        = M_HIGH;
         last_rise = k;
      end else if (ms != M_STUCK && el >= TOUT) begin
         last_lvl = l;
         exp_q.push_back(mk(l ? TOUT : 0, TOUT, l ? 15 : 0, 1'b0, 1'b1, l));
         ms = M_STUCK;
      end else if (fall && ms == M_HIGH) begin
         hi_len = el;
         ms     = M_LOW;
      end
   endtask

   initial begin
      bit cur;
      forever begin
         @(posedge clk);
         cyc++;
         cur = pwm_in;
         if (reset) begin
            // Reset discards the event two samples back and zeroes the line
            // history; the counter restarts as if a rise happened at cyc-1.
            ms        = M_ARM;
            prev_l    = 1'b0;
            last_lvl  = 1'b0;
            last_rise = cyc - 1;
            d1        = 1'b0;
            cur       = 1'b0;
         end else begin
            model_step(cyc - 2, d2);
         end
         d2 = d1;
         d1 = cur;
      end
   end

   // Monitor: compare every presented measurement against the scoreboard
   initial begin
      rec_t got;
      rec_t want;
      forever begin
         @(negedge clk);
         if (meas_valid === 1'b1) begin
            got = {high_cycles, period_cycles, duty, period_match, stuck, stuck_level};
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_meas t=%0t: got hi=%0d per=%0d duty=%0d match=%0b stuck=%0b lvl=%0b, none expected",
                        $time, got.hi, got.per, got.dty, got.match, got.stk, got.lvl);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  n_fail++;
                  $display("FAIL meas t=%0t: got hi=%0d per=%0d duty=%0d match=%0b stuck=%0b lvl=%0b, want hi=%0d per=%0d duty=%0d match=%0b stuck=%0b lvl=%0b",
                           $time, got.hi, got.per, got.dty, got.match, got.stk, got.lvl,
                           want.hi, want.per, want.dty, want.match, want.stk, want.lvl);
               end
            end
         end
      end
   end

   task automatic hold(input bit l, input int n);
      pwm_in = l;
      repeat (n) @(negedge clk);
   endtask

   task automatic gen(input int d, input int periods);
      for (int p = 0; p < periods; p++) begin
         if (d > 0) hold(1'b1, d);
         if (d < NOM) hold(1'b0, NOM - d);
      end
   endtask

   task automatic check_zero(input string name);
      n_tests++;
      if ({high_cycles, period_cycles, duty, period_match, stuck, stuck_level, meas_valid} !== '0) begin
         n_fail++;
         $display("FAIL %s: got hi=%0d per=%0d duty=%0d match=%0b stuck=%0b lvl=%0b valid=%0b, want all 0",
                  name, high_cycles, period_cycles, duty, period_match, stuck,
                  stuck_level, meas_valid);
      end
   endtask

   initial begin
      reset  = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      reset = 1'b0;

      gen(5, 6);
      gen(1, 4);
      gen(8, 4);
      gen(15, 4);
      hold(1'b0, 60);
      hold(1'b1, 50);
      gen(3, 4);
      for (int i = 0; i < 3; i++) begin
         hold(1'b1, 20);
         hold(1'b0, 12);
      end
      gen(6, 3);

      // Reset while the line is high (FSM in HIGH)
      hold(1'b1, 3);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("reset_in_high");
      reset = 1'b0;
      hold(1'b1, 2);
      hold(1'b0, 10);
      gen(6, 4);

      for (int i = 0; i < 40; i++) begin
         hold(1'b1, $urandom_range(1, 40));
         hold(1'b0, $urandom_range(1, 40));
      end
      for (int i = 0; i < 30; i++) begin
         hold(1'b1, $urandom_range(1, 20));
         hold(1'b0, $urandom_range(1, 20));
      end
      hold(1'b0, 45);

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_expected: got %0d measurements missing, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
